// File: rtl/pixel_buffer_unit.sv
// Pixel buffer between shader and frame buffer: small in-order FIFO plus an
// output register that drives a req/ack write port, with frame counting.
module pixel_buffer_unit #(
    parameter int PIXEL_W    = 19,
    parameter int COLOR_W    = 24,
    parameter int DEPTH      = 8,
    parameter int NUM_PIXELS = 307200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pb_we,
    input  logic [PIXEL_W+COLOR_W-1:0] pb_data_in,
    output logic                       pb_full,
    output logic                       fb_wr_req,
    output logic [PIXEL_W-1:0]         fb_wr_addr,
    output logic [COLOR_W-1:0]         fb_wr_data,
    input  logic                       fb_wr_ack,
    output logic                       frame_done,
    output logic [PIXEL_W-1:0]         pixel_cnt,
    output logic                       overflow,
    output logic                       bad_pixel
);

    localparam int DW    = PIXEL_W + COLOR_W;
    localparam int SLOTS = DEPTH - 1;
    localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW    = $clog2(DEPTH);

    localparam logic [PIXEL_W-1:0] NUM_PIX   = PIXEL_W'(NUM_PIXELS);
    localparam logic [PIXEL_W-1:0] LAST_PIX  = PIXEL_W'(NUM_PIXELS - 1);
    localparam logic [PW-1:0]      LAST_SLOT = PW'(SLOTS - 1);
    localparam logic [CW-1:0]      FULL_CNT  = CW'(SLOTS);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pixel_buffer_unit: DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        out_q, out_d;
    logic [DW-1:0]        mem_q [SLOTS];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [PIXEL_W-1:0]   pixel_cnt_q, pixel_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overflow_q, overflow_d;
    logic                 bad_pixel_q, bad_pixel_d;

    logic [PIXEL_W-1:0]   pix_id;
    logic                 id_ok;
    logic                 busy;
    logic                 accept;
    logic                 ack_fire;
    logic                 out_free;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bypass;

    // Full means every FIFO slot is used and the output register holds a pixel.
    assign pix_id     = pb_data_in[DW-1 -: PIXEL_W];
    assign id_ok      = (pix_id < NUM_PIX);
    assign busy       = (state_q == BUSY);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pb_full    = busy && (fifo_cnt_q == FULL_CNT);
    assign accept     = pb_we && !pb_full && id_ok;
    assign ack_fire   = busy && fb_wr_ack;
    assign out_free   = !busy || fb_wr_ack;

    // The output register refills from the FIFO head first; a new write only
    // bypasses the FIFO when there is nothing older waiting.
    assign pop    = out_free && !fifo_empty;
    assign bypass = out_free && fifo_empty && accept;
    assign push   = accept && !bypass;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    out_d   = mem_q[rd_ptr_q];
                    state_d = BUSY;
                end else if (bypass) begin
                    out_d   = pb_data_in;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (fb_wr_ack) begin
                    if (pop) begin
                        out_d = mem_q[rd_ptr_q];
                    end else if (bypass) begin
                        out_d = pb_data_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_comb begin
        pixel_cnt_d  = pixel_cnt_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q || (pb_we && pb_full);
        bad_pixel_d  = bad_pixel_q || (pb_we && !id_ok);
        if (ack_fire) begin
            if (pixel_cnt_q == LAST_PIX) begin
                pixel_cnt_d  = '0;
                frame_done_d = 1'b1;
            end else begin
                pixel_cnt_d = pixel_cnt_q + PIXEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            pixel_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            bad_pixel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            pixel_cnt_q  <= pixel_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            bad_pixel_q  <= bad_pixel_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= pb_data_in;
        end
    end

    assign fb_wr_req  = busy;
    assign fb_wr_addr = out_q[DW-1 -: PIXEL_W];
    assign fb_wr_data = out_q[COLOR_W-1:0];
    assign frame_done = frame_done_q;
    assign pixel_cnt  = pixel_cnt_q;
    assign overflow   = overflow_q;
    assign bad_pixel  = bad_pixel_q;

endmodule

// File: tb/tb_pixel_buffer_unit.sv
// Bench for pixel_buffer_unit: directed vector table, then randomized traffic
// checked against a queue-based model of the buffer and frame counter.
module tb_pixel_buffer_unit;

    localparam int PIXEL_W    = 19;
    localparam int COLOR_W    = 24;
    localparam int DEPTH      = 8;
    localparam int NUM_PIXELS = 16;
    localparam int DW         = PIXEL_W + COLOR_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pb_we = 1'b0;
    logic [DW-1:0]      pb_data_in = '0;
    logic               pb_full;
    logic               fb_wr_req;
    logic [PIXEL_W-1:0] fb_wr_addr;
    logic [COLOR_W-1:0] fb_wr_data;
    logic               fb_wr_ack = 1'b0;
    logic               frame_done;
    logic [PIXEL_W-1:0] pixel_cnt;
    logic               overflow;
    logic               bad_pixel;

    int checks   = 0;
    int failures = 0;

    pixel_buffer_unit #(
        .PIXEL_W   (PIXEL_W),
        .COLOR_W   (COLOR_W),
        .DEPTH     (DEPTH),
        .NUM_PIXELS(NUM_PIXELS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_we     (pb_we),
        .pb_data_in(pb_data_in),
        .pb_full   (pb_full),
        .fb_wr_req (fb_wr_req),
        .fb_wr_addr(fb_wr_addr),
        .fb_wr_data(fb_wr_data),
        .fb_wr_ack (fb_wr_ack),
        .frame_done(frame_done),
        .pixel_cnt (pixel_cnt),
        .overflow  (overflow),
        .bad_pixel (bad_pixel)
    );

    always #5 clk = ~clk;

    // Reference model: the whole buffer is one in-order queue whose head is
    // what the frame-buffer port must be showing.
    logic [DW-1:0] exp_q[$];
    int            m_cnt = 0;
    logic          m_fd  = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_bad = 1'b0;

    typedef struct {
        logic               we;
        logic [PIXEL_W-1:0] id;
        logic [COLOR_W-1:0] col;
        logic               ack;
        logic               req;
        logic [PIXEL_W-1:0] addr;
        logic [COLOR_W-1:0] data;
        logic               full;
        logic [PIXEL_W-1:0] cnt;
        logic               fd;
        logic               ovf;
        logic               bad;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [COLOR_W-1:0] col_of(input int id);
        return COLOR_W'(24'hC00000 + id);
    endfunction

    task automatic model_edge(input logic we, input logic [DW-1:0] d, input logic ack, input logic r);
        logic was_full;
        logic [PIXEL_W-1:0] id;
        if (r) begin
            exp_q.delete();
            m_cnt = 0;
            m_fd  = 1'b0;
            m_ovf = 1'b0;
            m_bad = 1'b0;
            return;
        end
        was_full = (exp_q.size() == DEPTH);
        id       = d[DW-1 -: PIXEL_W];
        m_fd     = 1'b0;
        if (ack && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            m_cnt = (m_cnt + 1) % NUM_PIXELS;
            if (m_cnt == 0) m_fd = 1'b1;
        end
        if (we) begin
            if (was_full) m_ovf = 1'b1;
            if (id >= NUM_PIXELS) m_bad = 1'b1;
            if (!was_full && id < NUM_PIXELS) exp_q.push_back(d);
        end
    endtask

    task automatic model_check(input string tag);
        logic [DW-1:0] head;
        chk({tag, "_req"}, fb_wr_req, exp_q.size() != 0);
        chk({tag, "_full"}, pb_full, exp_q.size() == DEPTH);
        chk({tag, "_cnt"}, pixel_cnt, m_cnt);
        chk({tag, "_fd"}, frame_done, m_fd);
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_bad"}, bad_pixel, m_bad);
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk({tag, "_addr"}, fb_wr_addr, head[DW-1 -: PIXEL_W]);
            chk({tag, "_data"}, fb_wr_data, head[COLOR_W-1:0]);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic step(input logic we, input logic [PIXEL_W-1:0] id,
                        input logic [COLOR_W-1:0] col, input logic ack);
        pb_we      = we;
        pb_data_in = {id, col};
        fb_wr_ack  = ack;
        @(posedge clk);
        model_edge(we, {id, col}, ack, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ack);
        rst        = 1'b1;
        pb_we      = 1'b0;
        fb_wr_ack  = ack;
        @(posedge clk);
        model_edge(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        rst       = 1'b0;
        fb_wr_ack = 1'b0;
    endtask

    task automatic add_vec(input logic we, input int id, input logic [COLOR_W-1:0] col,
                           input logic ack, input logic req, input int addr,
                           input logic [COLOR_W-1:0] data, input logic full, input int cnt,
                           input logic fd, input logic ovf, input logic bad);
        vecs.push_back('{we, PIXEL_W'(id), col, ack, req, PIXEL_W'(addr), data,
                         full, PIXEL_W'(cnt), fd, ovf, bad});
    endtask

    initial begin
        int accepted;
        int cyc;
        int ack_pct;
        logic we;
        logic ack;
        logic [PIXEL_W-1:0] id;
        logic [COLOR_W-1:0] col;

        // Single pixel with ack tied high.
        add_vec(1, 5, 24'hFF0000, 1, 1, 5, 24'hFF0000, 0, 0, 0, 0, 0);
        add_vec(0, 0, 24'h0, 1, 0, 0, 24'h0, 0, 1, 0, 0, 0);
        // Fill to DEPTH with ack low.
        for (int i = 0; i < 8; i++)
            add_vec(1, i, col_of(i), 0, 1, 0, col_of(0), i == 7, 1, 0, 0, 0);
        // Write while full is dropped.
        add_vec(1, 9, col_of(9), 0, 1, 0, col_of(0), 1, 1, 0, 1, 0);
        // Drain in order.
        for (int k = 1; k < 8; k++)
            add_vec(0, 0, 24'h0, 1, 1, k, col_of(k), 0, k + 1, 0, 1, 0);
        add_vec(0, 0, 24'h0, 1, 0, 0, 24'h0, 0, 9, 0, 1, 0);
        // Out-of-range pixel.
        add_vec(1, NUM_PIXELS, col_of(16), 1, 0, 0, 24'h0, 0, 9, 0, 1, 1);
        // Streaming bypass through the frame wrap.
        for (int i = 0; i < 8; i++)
            add_vec(1, i, col_of(i), 1, 1, i, col_of(i), 0, (9 + i) % NUM_PIXELS,
                    i == 7, 1, 1);
        add_vec(0, 0, 24'h0, 1, 0, 0, 24'h0, 0, 1, 0, 1, 1);

        repeat (2) @(posedge clk);
        do_reset(1'b0);
        chk("rst_req", fb_wr_req, 1'b0);
        chk("rst_full", pb_full, 1'b0);
        chk("rst_addr", fb_wr_addr, 0);
        chk("rst_data", fb_wr_data, 0);
        chk("rst_cnt", pixel_cnt, 0);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_bad", bad_pixel, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].id, vecs[i].col, vecs[i].ack);
            chk($sformatf("v%0d_req", i), fb_wr_req, vecs[i].req);
            chk($sformatf("v%0d_full", i), pb_full, vecs[i].full);
            chk($sformatf("v%0d_cnt", i), pixel_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_fd", i), frame_done, vecs[i].fd);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
            chk($sformatf("v%0d_bad", i), bad_pixel, vecs[i].bad);
            if (vecs[i].req) begin
                chk($sformatf("v%0d_addr", i), fb_wr_addr, vecs[i].addr);
                chk($sformatf("v%0d_data", i), fb_wr_data, vecs[i].data);
            end
        end

        // Randomized traffic against the model.
        do_reset(1'b0);
        model_check("rnd_rst");
        accepted = 0;
        cyc      = 0;
        ack_pct  = 50;
        while (accepted < 100 && cyc < 5000) begin
            if (cyc % 32 == 0) ack_pct = $urandom_range(10, 90);
            we = ($urandom_range(0, 3) != 0);
            if (exp_q.size() == DEPTH && $urandom_range(0, 3) != 0) we = 1'b0;
            if ($urandom_range(0, 19) == 0)
                id = PIXEL_W'(NUM_PIXELS + $urandom_range(0, 3));
            else
                id = PIXEL_W'($urandom_range(0, NUM_PIXELS - 1));
            col = COLOR_W'($urandom);
            ack = ($urandom_range(0, 99) < ack_pct);
            if (we && exp_q.size() != DEPTH && id < NUM_PIXELS) accepted++;
            step(we, id, col, ack);
            model_check("rnd");
            cyc++;
        end
        chk("rnd_accept_budget", accepted, 100);

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            step(1'b0, '0, '0, 1'b1);
            model_check("drain");
            cyc++;
        end
        chk("drain_budget", exp_q.size(), 0);

        // Reset mid-stream with an ack in the reset cycle.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, PIXEL_W'(i), col_of(i + 40), 1'b0);
            model_check("pre_rst");
        end
        do_reset(1'b1);
        chk("mid_rst_req", fb_wr_req, 1'b0);
        chk("mid_rst_full", pb_full, 1'b0);
        chk("mid_rst_cnt", pixel_cnt, 0);
        model_check("mid_rst");
        step(1'b1, PIXEL_W'(3), col_of(3), 1'b1);
        model_check("post_rst");
        step(1'b0, '0, '0, 1'b1);
        model_check("post_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
